// File: rtl/edge_detect_multi.sv
// Multi-channel edge detector: per-channel mode select, sticky flag and saturating event counter.
// Optional glitch filter is compiled in by defining EDGE_FILTER_EN.
module edge_detect_multi #(
   parameter int unsigned N_CH     = 4,
   parameter int unsigned CNT_W    = 4,
   parameter int unsigned OUT_TYPE = 0,
   parameter int unsigned FILT_CYC = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [N_CH-1:0]       in_edge,
   input  logic [2*N_CH-1:0]     mode,
   input  logic [N_CH-1:0]       clr,
   output logic [N_CH-1:0]       out_edge,
   output logic                  any_edge,
   output logic [N_CH-1:0]       edge_flag,
   output logic [N_CH*CNT_W-1:0] edge_cnt
);
   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_LOW  = 2'd1,
      ST_HIGH = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t           state_q [N_CH];
   state_t           state_d [N_CH];
   logic [CNT_W-1:0] cnt_q   [N_CH];
   logic [CNT_W-1:0] cnt_d   [N_CH];
   logic [N_CH-1:0]  flag_q;
   logic [N_CH-1:0]  flag_d;
   logic [N_CH-1:0]  commit_s;
   logic [N_CH-1:0]  qual_s;

`ifdef EDGE_FILTER_EN
   localparam int unsigned FW = $clog2(FILT_CYC + 1);

   logic [FW-1:0] filt_q [N_CH];
   logic [FW-1:0] filt_d [N_CH];

   // A level change is accepted only on the FILT_CYC-th consecutive differing sample
   always_comb begin
      filt_d   = filt_q;
      commit_s = {N_CH{1'b0}};
      for (int i = 0; i < N_CH; i++) begin
         if (((state_q[i] == ST_LOW) && in_edge[i]) || ((state_q[i] == ST_HIGH) && !in_edge[i])) begin
            if (filt_q[i] == FW'(FILT_CYC - 1)) begin
               commit_s[i] = 1'b1;
               filt_d[i]   = {FW{1'b0}};
            end else begin
               commit_s[i] = 1'b0;
               filt_d[i]   = filt_q[i] + FW'(1);
            end
         end else begin
            commit_s[i] = 1'b0;
            filt_d[i]   = {FW{1'b0}};
         end
      end
   end

   // Filter counter registers
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N_CH; i++) begin
            filt_q[i] <= {FW{1'b0}};
         end
      end else begin
         filt_q <= filt_d;
      end
   end
`else
   // Any sample differing from the tracked level is a level change
   always_comb begin
      commit_s = {N_CH{1'b0}};
      for (int i = 0; i < N_CH; i++) begin
         commit_s[i] = ((state_q[i] == ST_LOW) && in_edge[i]) ||
                       ((state_q[i] == ST_HIGH) && !in_edge[i]);
      end
   end
`endif

   // Per-channel next state, event qualification, flag and counter update
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      flag_d  = flag_q;
      qual_s  = {N_CH{1'b0}};
      for (int i = 0; i < N_CH; i++) begin
         // Reset wins, so no event can be reported while it is asserted
         qual_s[i] = !reset &&
                     ((commit_s[i] && (state_q[i] == ST_LOW)  && mode[2*i]) ||
                      (commit_s[i] && (state_q[i] == ST_HIGH) && mode[2*i+1]));
         case (state_q[i])
            ST_INIT: state_d[i] = in_edge[i] ? ST_HIGH : ST_LOW;
            ST_LOW:  state_d[i] = commit_s[i] ? ST_HIGH : ST_LOW;
            ST_HIGH: state_d[i] = commit_s[i] ? ST_LOW : ST_HIGH;
            default: state_d[i] = ST_INIT;
         endcase
         if (qual_s[i]) begin
            flag_d[i] = 1'b1;
         end else if (clr[i]) begin
            flag_d[i] = 1'b0;
         end else begin
            flag_d[i] = flag_q[i];
         end
         if (qual_s[i] && clr[i]) begin
            cnt_d[i] = CNT_W'(1);
         end else if (clr[i]) begin
            cnt_d[i] = {CNT_W{1'b0}};
         end else if (qual_s[i] && (cnt_q[i] != CNT_MAX)) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end else begin
            cnt_d[i] = cnt_q[i];
         end
      end
   end

   // Channel state, flag and counter registers
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N_CH; i++) begin
            state_q[i] <= ST_INIT;
            cnt_q[i]   <= {CNT_W{1'b0}};
         end
         flag_q <= {N_CH{1'b0}};
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         flag_q  <= flag_d;
      end
   end

   if (OUT_TYPE == 1) begin : g_moore
      logic [N_CH-1:0] pulse_q;

      // Pulse register: event shows one cycle after the committing edge
      always_ff @(posedge clk) begin
         if (reset) begin
            pulse_q <= {N_CH{1'b0}};
         end else begin
            pulse_q <= qual_s;
         end
      end

      assign out_edge = pulse_q;
   end else begin : g_mealy
      assign out_edge = qual_s;
   end

   for (genvar g = 0; g < N_CH; g++) begin : g_cnt_out
      assign edge_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
   end

   assign edge_flag = flag_q;
   assign any_edge  = |out_edge;
endmodule
